// File: rtl/subleq_abc_pkg.sv
// rtl/subleq_abc_pkg.sv - state codes shared by the SUBLEQ control FSM, datapath and PC incrementer
package subleq_abc_pkg;

    localparam logic [2:0] S_FETCH_ABC    = 3'd0;
    localparam logic [2:0] S_LOAD_ABC     = 3'd1;
    localparam logic [2:0] S_FETCH_MEM_AB = 3'd2;
    localparam logic [2:0] S_LOAD_MEM_AB  = 3'd3;
    localparam logic [2:0] S_EXECUTE      = 3'd4;
    localparam logic [2:0] S_WRITEBACK    = 3'd5;
    // The datapath holds PC for the two codes below.
    localparam logic [2:0] S_IDLE         = 3'd6;
    localparam logic [2:0] S_HALTED       = 3'd7;

    function automatic logic is_fetch(input logic [2:0] s);
        return (s == S_FETCH_ABC) || (s == S_FETCH_MEM_AB);
    endfunction

endpackage

// File: rtl/control_abc.sv
// rtl/control_abc.sv - SUBLEQ sequencing FSM with run/step/halt, memory-wait dwell and retired-instruction counter
module control_abc
    import subleq_abc_pkg::*;
#(
    parameter int MEM_WAIT  = 0,
    parameter int MAX_INSTR = 0,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             halt_req,
    input  logic             zero,
    input  logic             negative,
    output logic             abc_ld,
    output logic             mem_ab_ld,
    output logic             result_ld,
    output logic             read_en_abc,
    output logic             read_en_ab,
    output logic             write_en_b,
    output logic             pc_ld,
    output logic [2:0]       state,
    output logic             running,
    output logic             halted,
    output logic             branch_taken,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0]       WAIT_INIT = 4'(MEM_WAIT);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_INSTR);

    logic [2:0]       state_r;
    logic [2:0]       state_n;
    logic [3:0]       wait_cnt;
    logic             halt_pending;
    logic             step_mode;
    logic [CNT_W-1:0] count_next;
    logic             limit_hit;
    logic             halt_now;
    logic             is_running;

    assign state      = state_r;
    assign is_running = (state_r != S_IDLE) && (state_r != S_HALTED);
    assign count_next = (instr_count == '1) ? instr_count : instr_count + CNT_W'(1);
    assign limit_hit  = (MAX_INSTR != 0) && (count_next == MAX_C);
    assign halt_now   = halt_pending | halt_req | limit_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            wait_cnt     <= '0;
            halt_pending <= 1'b0;
            step_mode    <= 1'b0;
            instr_count  <= '0;
            branch_taken <= 1'b0;
        end else begin
            state_r <= state_n;
            // Reload on entry so each FETCH state dwells MEM_WAIT+1 cycles.
            if (is_fetch(state_n) && (state_n != state_r))
                wait_cnt <= WAIT_INIT;
            else if (is_fetch(state_r) && (wait_cnt != '0))
                wait_cnt <= wait_cnt - 4'd1;

            if (state_n == S_HALTED)
                halt_pending <= 1'b0;
            else if (is_running && halt_req)
                halt_pending <= 1'b1;

            if ((state_r == S_IDLE || state_r == S_HALTED) && start)
                step_mode <= 1'b0;
            else if (state_r == S_IDLE && step)
                step_mode <= 1'b1;

            if (state_r == S_WRITEBACK)
                instr_count <= count_next;
            branch_taken <= (state_r == S_WRITEBACK) && (zero | negative);
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE: begin
                if (start || step)
                    state_n = S_FETCH_ABC;
                else if (halt_req)
                    state_n = S_HALTED;
            end
            S_FETCH_ABC:    state_n = (wait_cnt == '0) ? S_LOAD_ABC : S_FETCH_ABC;
            S_LOAD_ABC:     state_n = S_FETCH_MEM_AB;
            S_FETCH_MEM_AB: state_n = (wait_cnt == '0) ? S_LOAD_MEM_AB : S_FETCH_MEM_AB;
            S_LOAD_MEM_AB:  state_n = S_EXECUTE;
            S_EXECUTE:      state_n = S_WRITEBACK;
            S_WRITEBACK: begin
                if (halt_now)
                    state_n = S_HALTED;
                else if (step_mode)
                    state_n = S_IDLE;
                else
                    state_n = S_FETCH_ABC;
            end
            S_HALTED: begin
                if (start)
                    state_n = S_FETCH_ABC;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        abc_ld      = 1'b0;
        mem_ab_ld   = 1'b0;
        result_ld   = 1'b0;
        read_en_abc = 1'b0;
        read_en_ab  = 1'b0;
        write_en_b  = 1'b0;
        pc_ld       = 1'b0;
        running     = is_running;
        halted      = (state_r == S_HALTED);
        case (state_r)
            S_FETCH_ABC:    read_en_abc = 1'b1;
            S_LOAD_ABC: begin
                read_en_abc = 1'b1;
                abc_ld      = 1'b1;
            end
            S_FETCH_MEM_AB: read_en_ab = 1'b1;
            S_LOAD_MEM_AB: begin
                read_en_ab = 1'b1;
                mem_ab_ld  = 1'b1;
            end
            S_EXECUTE:      result_ld = 1'b1;
            // Flags are stable here because mem_a/mem_b are not reloaded.
            S_WRITEBACK: begin
                write_en_b = 1'b1;
                pc_ld      = zero | negative;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_abc.sv
// tb/tb_control_abc.sv - scoreboard bench for control_abc with a default and a MEM_WAIT=2/MAX_INSTR=3 instance
module tb_control_abc;
    import subleq_abc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] start = '0, step = '0, halt_req = '0, zero = '0, negative = '0;
    logic [1:0] abc_ld, mem_ab_ld, result_ld, read_en_abc, read_en_ab, write_en_b, pc_ld;
    logic [1:0] running, halted, branch_taken;
    logic [2:0]  st  [2];
    logic [31:0] cnt [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        control_abc #(
            .MEM_WAIT ((g == 0) ? 0 : 2),
            .MAX_INSTR((g == 0) ? 0 : 3),
            .CNT_W    (32)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[g]),
            .step        (step[g]),
            .halt_req    (halt_req[g]),
            .zero        (zero[g]),
            .negative    (negative[g]),
            .abc_ld      (abc_ld[g]),
            .mem_ab_ld   (mem_ab_ld[g]),
            .result_ld   (result_ld[g]),
            .read_en_abc (read_en_abc[g]),
            .read_en_ab  (read_en_ab[g]),
            .write_en_b  (write_en_b[g]),
            .pc_ld       (pc_ld[g]),
            .state       (st[g]),
            .running     (running[g]),
            .halted      (halted[g]),
            .branch_taken(branch_taken[g]),
            .instr_count (cnt[g])
        );
    end

    typedef struct {
        bit          pc_ld;
        int unsigned count;
        int unsigned cyc;
    } wb_t;

    wb_t         exp_q [2][$];
    wb_t         last  [2];
    bit          bt_pend [2] = '{0, 0};
    int unsigned mcount  [2] = '{0, 0};
    int          mw      [2] = '{0, 2};
    int          maxi    [2] = '{0, 3};
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction position j -> state code, straight from the dwell rule.
    function automatic logic [2:0] phase(input int w, input int j);
        if (j <= w)         return 3'd0;
        if (j == w + 1)     return 3'd1;
        if (j <= 2 * w + 2) return 3'd2;
        if (j == 2 * w + 3) return 3'd3;
        if (j == 2 * w + 4) return 3'd4;
        return 3'd5;
    endfunction

    // {abc_ld, mem_ab_ld, result_ld, read_en_abc, read_en_ab, write_en_b, running, halted}
    function automatic logic [7:0] exp_en(input logic [2:0] s);
        case (s)
            3'd0: return 8'b000_100_10;
            3'd1: return 8'b100_100_10;
            3'd2: return 8'b000_010_10;
            3'd3: return 8'b010_010_10;
            3'd4: return 8'b001_000_10;
            3'd5: return 8'b000_001_10;
            3'd6: return 8'b000_000_00;
            default: return 8'b000_000_01;
        endcase
    endfunction

    function automatic logic [7:0] act_en(input int i);
        return {abc_ld[i], mem_ab_ld[i], result_ld[i], read_en_abc[i],
                read_en_ab[i], write_en_b[i], running[i], halted[i]};
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bt_pend[i]) begin
                check("branch_taken", 64'(branch_taken[i]), 64'(last[i].pc_ld));
                check("instr_count", 64'(cnt[i]), 64'(last[i].count));
                bt_pend[i] = 0;
            end
            if (write_en_b[i] === 1'b1) begin
                if (exp_q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_writeback: dut%0d wrote back with nothing expected", i);
                end else begin
                    last[i] = exp_q[i].pop_front();
                    check("pc_ld", 64'(pc_ld[i]), 64'(last[i].pc_ld));
                    check("wb_cycle", 64'(cyc), 64'(last[i].cyc));
                    bt_pend[i] = 1;
                end
            end
        end
    end

    // mode: 0 start, 1 step, 2 start+step together. Called at a negedge.
    task automatic run_prog(input int d, input int mode, input int n, input int halt_at, input bit force_first);
        int          lat;
        int unsigned base;
        bit          stop;
        bit          hlt;
        int          a, b, r;
        lat  = 4 + 2 * (mw[d] + 1);
        base = cyc;
        stop = 0;
        hlt  = 0;
        if (mode != 1) start[d] = 1'b1;
        if (mode != 0) step[d]  = 1'b1;
        for (int k = 0; k < n && !stop; k++) begin
            for (int j = 0; j < lat; j++) begin
                @(negedge clk);
                start[d]    = 1'b0;
                step[d]     = 1'b0;
                halt_req[d] = 1'b0;
                if (j == 0) begin
                    a = int'($urandom_range(16)) - 8;
                    b = int'($urandom_range(16)) - 8;
                    if (force_first && k == 0) begin a = 5; b = 3; end
                    if (force_first && k == 1) begin a = 1; b = 4; end
                    r = b - a;
                    zero[d]     = (r == 0);
                    negative[d] = (r < 0);
                    mcount[d]++;
                    exp_q[d].push_back('{pc_ld: (r <= 0), count: mcount[d],
                                         cyc: base + unsigned'((k + 1) * lat)});
                end
                check("state", 64'(st[d]), 64'(phase(mw[d], j)));
                check("enables", 64'(act_en(d)), 64'(exp_en(phase(mw[d], j))));
                if (k == halt_at && j == lat - 2) halt_req[d] = 1'b1;
            end
            hlt  = (k == halt_at) || (maxi[d] != 0 && mcount[d] == unsigned'(maxi[d]));
            stop = hlt || (mode == 1);
        end
        @(negedge clk);
        check("end_state", 64'(st[d]), hlt ? 64'd7 : (mode == 1) ? 64'd6 : 64'd0);
        check("end_enables", 64'(act_en(d)), 64'(exp_en(hlt ? 3'd7 : (mode == 1) ? 3'd6 : 3'd0)));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_state", 64'(st[i]), 64'd6);
            check("reset_enables", 64'(act_en(i)), 64'd0);
            check("reset_count", 64'(cnt[i]), 64'd0);
            check("reset_branch", 64'(branch_taken[i]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Branching and non-branching instructions, halt during EXECUTE of the 4th.
        run_prog(0, 0, 6, 3, 1'b1);
        step[0] = 1'b1;
        @(negedge clk);
        step[0] = 1'b0;
        @(negedge clk);
        check("step_in_halted", 64'(st[0]), 64'd7);
        run_prog(0, 0, 3, 2, 1'b0);

        // Single step with MEM_WAIT=2, then halt_req from IDLE.
        run_prog(1, 1, 1, -1, 1'b0);
        halt_req[1] = 1'b1;
        @(negedge clk);
        halt_req[1] = 1'b0;
        check("idle_halt", 64'(st[1]), 64'd7);

        // Asynchronous reset in LOAD_MEM_AB.
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_state", 64'(st[0]), 64'd3);
        rst = 1'b1;
        #1;
        check("async_reset_state", 64'(st[0]), 64'd6);
        check("async_reset_enables", 64'(act_en(0)), 64'd0);
        check("async_reset_count", 64'(cnt[0]), 64'd0);
        check("async_reset_dut1", 64'(st[1]), 64'd6);
        exp_q[0].delete();
        exp_q[1].delete();
        mcount[0] = 0;
        mcount[1] = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_state", 64'(st[0]), 64'd6);

        // start+step together runs continuously.
        run_prog(0, 2, 2, 1, 1'b0);

        // Auto-halt after three retired instructions.
        run_prog(1, 0, 10, -1, 1'b0);
        check("max_instr_count", 64'(cnt[1]), 64'd3);

        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check("scoreboard_drained", 64'(exp_q[i].size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
